shift_register_burst: RTL

SHIFT_REGISTER_BURST -- requirements
Module: shift_register_burst

---
 rtl/shift_register_pkg.sv | 22 ++
 rtl/shift_burst_ctrl.sv | 94 +++++++++
 rtl/shift_register_burst.sv | 94 +++++++++
 3 files changed

// File: rtl/shift_register_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_register_pkg
//  Description : Operation encoding and burst FSM state type shared by the
//                burst-capable shift register and its controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_register_pkg;

   localparam logic [1:0] MODE_SHIFT  = 2'b00;
   localparam logic [1:0] MODE_ROTATE = 2'b01;
   localparam logic [1:0] MODE_LOAD   = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : shift_register_pkg
`default_nettype wire

// File: rtl/shift_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_burst_ctrl
//  Description : Burst sequencer; selects the per-cycle operation (live
//                inputs in IDLE, latched mode/dir in RUN) and flags busy/done.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_burst_ctrl
   import shift_register_pkg::*;
#(
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [1:0]       mode_i,
   input  logic             dir_i,
   input  logic             burst_start_i,
   input  logic [CNT_W-1:0] burst_len_i,
   output logic             op_valid_o,
   output logic [1:0]       op_mode_o,
   output logic             op_dir_o,
   output logic             busy_o,
   output logic             done_o
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       mode_eff_q, mode_eff_d;
   logic             dir_eff_q, dir_eff_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         mode_eff_q <= MODE_SHIFT;
         dir_eff_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         mode_eff_q <= mode_eff_d;
         dir_eff_q  <= dir_eff_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      mode_eff_d = mode_eff_q;
      dir_eff_d  = dir_eff_q;
      op_valid_o = 1'b0;
      op_mode_o  = mode_i;
      op_dir_o   = dir_i;
      case (state_q)
         ST_IDLE: begin
            // A burst request pre-empts any en-driven operation this cycle
            if (burst_start_i) begin
               if (burst_len_i != '0) begin
                  mode_eff_d = mode_i;
                  dir_eff_d  = dir_i;
                  count_d    = burst_len_i;
                  state_d    = ST_RUN;
               end else begin
                  state_d    = ST_DONE;
               end
            end else begin
               op_valid_o = en_i;
            end
         end
         ST_RUN: begin
            op_valid_o = 1'b1;
            op_mode_o  = mode_eff_q;
            op_dir_o   = dir_eff_q;
            count_d    = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            op_mode_o = mode_eff_q;
            op_dir_o  = dir_eff_q;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy_o = (state_q != ST_IDLE);
   assign done_o = (state_q == ST_DONE);

endmodule : shift_burst_ctrl
`default_nettype wire

// File: rtl/shift_register_burst.sv
`default_nettype none
// ============================================================================
//  Module      : shift_register_burst
//  Description : DEPTH x WIDTH shift/rotate/load register with an autonomous
//                multi-step burst mode driven by shift_burst_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_register_burst
   import shift_register_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int WIDTH = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [1:0]                   mode,
   input  logic                         shift_dir,
   input  logic [WIDTH-1:0]             din,
   input  logic [DEPTH*WIDTH-1:0]       load_data,
   input  logic                         burst_start,
   input  logic [$clog2(DEPTH+1)-1:0]   burst_len,
   output logic [WIDTH-1:0]             dout,
   output logic [DEPTH*WIDTH-1:0]       par_out,
   output logic                         busy,
   output logic                         done
);

   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DEPTH*WIDTH-1:0] data_q, data_d;
   logic                   w_op_valid;
   logic [1:0]             w_op_mode;
   logic                   w_op_dir;
   logic [WIDTH-1:0]       w_in;
   logic [WIDTH-1:0]       w_low;
   logic [WIDTH-1:0]       w_high;

   shift_burst_ctrl #(
      .CNT_W (CNT_W)
   ) u_ctrl (
      .clk           (clk),
      .rst           (rst),
      .en_i          (en),
      .mode_i        (mode),
      .dir_i         (shift_dir),
      .burst_start_i (burst_start),
      .burst_len_i   (burst_len),
      .op_valid_o    (w_op_valid),
      .op_mode_o     (w_op_mode),
      .op_dir_o      (w_op_dir),
      .busy_o        (busy),
      .done_o        (done)
   );

   assign w_low  = data_q[WIDTH-1:0];
   assign w_high = data_q[DEPTH*WIDTH-1 -: WIDTH];

   always_comb begin
      data_d = data_q;
      w_in   = din;
      // Rotation feeds back the entry leaving the far end
      if (w_op_mode == MODE_ROTATE) begin
         w_in = w_op_dir ? w_low : w_high;
      end
      if (w_op_valid) begin
         case (w_op_mode)
            MODE_SHIFT, MODE_ROTATE: begin
               if (w_op_dir) begin
                  data_d = {w_in, data_q[DEPTH*WIDTH-1:WIDTH]};
               end else begin
                  data_d = {data_q[(DEPTH-1)*WIDTH-1:0], w_in};
               end
            end
            MODE_LOAD: data_d = load_data;
            default:   data_d = data_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   // Outside IDLE the controller reports the latched burst direction
   assign dout    = w_op_dir ? w_low : w_high;
   assign par_out = data_q;

endmodule : shift_register_burst
`default_nettype wire
